// File: rtl/position_profile_control.sv
// Point-to-point position profiler: ramps PWM duty up, cruises, ramps down near the
// target and holds with brake, or passes the upstream drive straight through when disabled.
package position_profile_control_pkg;
    typedef enum logic [1:0] {
        DIR_NONE  = 2'd0,
        CW        = 2'd1,
        CCW       = 2'd2,
        DIR_BRAKE = 2'd3
    } rotation_direction_t;
endpackage

module position_profile_control
    import position_profile_control_pkg::*;
#(
    parameter int unsigned counter_width     = 32,
    parameter int unsigned pwm_counter_width = 32,
    parameter int unsigned pwm_min           = 100,
    parameter int unsigned pwm_max           = 300,
    parameter int unsigned ramp_step         = 50,
    parameter int unsigned update_divider    = 4,
    parameter int unsigned decel_distance    = 20,
    parameter int unsigned deadband          = 1,
    parameter int unsigned settle_cycles     = 8
) (
    input  logic                         sys_clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [counter_width-1:0]     encoder_position,
    input  logic [counter_width-1:0]     target_position,
    input  logic [pwm_counter_width-1:0] pwm_duty_in,
    input  rotation_direction_t          dir_in,
    input  logic                         driver_enable_in,
    output logic [pwm_counter_width-1:0] pwm_duty_out,
    output rotation_direction_t          dir_out,
    output logic                         driver_enable_out,
    output logic                         busy,
    output logic                         at_target
);

    localparam int unsigned CW_W   = counter_width;
    localparam int unsigned PW     = pwm_counter_width;
    localparam int unsigned TICK_W = (update_divider > 1) ? $clog2(update_divider) : 1;
    localparam int unsigned SET_W  = (settle_cycles > 0) ? $clog2(settle_cycles + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEL  = 3'd1,
        S_CRUISE = 3'd2,
        S_DECEL  = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       pwm_q, pwm_d;
    rotation_direction_t dir_q, dir_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [CW_W-1:0]     dist_q, dist_d;
    rotation_direction_t want_q, want_d;

    // Shortest signed path to target; the exact half-range error resolves to CCW.
    logic [CW_W-1:0] error_c;
    assign error_c = target_position - encoder_position;
    assign dist_d  = error_c[CW_W-1] ? (encoder_position - target_position) : error_c;
    assign want_d  = error_c[CW_W-1] ? CCW : CW;

    logic            in_band, near, dir_mis, tick_hit, decel_req;
    logic [PW:0]     pwm_up_sum;
    logic [PW-1:0]   pwm_up, pwm_dn;
    logic [TICK_W-1:0] tick_nxt;

    assign in_band    = dist_q <= CW_W'(deadband);
    assign near       = dist_q <= CW_W'(decel_distance);
    assign dir_mis    = want_q != dir_q;
    assign decel_req  = near || dir_mis;
    assign tick_hit   = tick_q == TICK_W'(update_divider - 1);
    assign tick_nxt   = tick_hit ? '0 : tick_q + TICK_W'(1);
    assign pwm_up_sum = {1'b0, pwm_q} + (PW+1)'(ramp_step);
    assign pwm_up     = (pwm_up_sum >= (PW+1)'(pwm_max)) ? PW'(pwm_max) : pwm_up_sum[PW-1:0];
    assign pwm_dn     = ((pwm_q > PW'(pwm_min)) && ((pwm_q - PW'(pwm_min)) > PW'(ramp_step)))
                        ? (pwm_q - PW'(ramp_step)) : PW'(pwm_min);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pwm_q    <= '0;
            dir_q    <= DIR_NONE;
            tick_q   <= '0;
            settle_q <= '0;
            dist_q   <= '0;
            want_q   <= CW;
        end else begin
            state_q  <= state_d;
            pwm_q    <= pwm_d;
            dir_q    <= dir_d;
            tick_q   <= tick_d;
            settle_q <= settle_d;
            dist_q   <= dist_d;
            want_q   <= want_d;
        end
    end

    // Next state: deadband beats decel, decel beats ramp completion.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   state_d = in_band ? S_HOLD : S_ACCEL;
                S_ACCEL: begin
                    if (in_band)                                 state_d = S_HOLD;
                    else if (decel_req)                          state_d = S_DECEL;
                    else if (tick_hit && pwm_up == PW'(pwm_max)) state_d = S_CRUISE;
                end
                S_CRUISE: begin
                    if (in_band)        state_d = S_HOLD;
                    else if (decel_req) state_d = S_DECEL;
                end
                S_DECEL: begin
                    if (in_band)                                state_d = S_HOLD;
                    else if (dir_mis && pwm_q == PW'(pwm_min))  state_d = S_ACCEL;
                    else if (!dir_mis && !near)                 state_d = S_ACCEL;
                end
                S_HOLD:   if (!in_band) state_d = S_ACCEL;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Duty, direction, tick and settle updates, mirroring the transition priorities.
    always_comb begin
        pwm_d    = pwm_q;
        dir_d    = dir_q;
        tick_d   = tick_q;
        settle_d = settle_q;
        if (!enable) begin
            pwm_d    = '0;
            dir_d    = DIR_NONE;
            tick_d   = '0;
            settle_d = '0;
        end else if (state_q != S_HOLD && state_q != S_IDLE && in_band) begin
            pwm_d    = '0;
            dir_d    = DIR_BRAKE;
            tick_d   = '0;
            settle_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tick_d   = '0;
                    settle_d = '0;
                    if (in_band) begin
                        pwm_d = '0;
                        dir_d = DIR_BRAKE;
                    end else begin
                        pwm_d = PW'(pwm_min);
                        dir_d = want_q;
                    end
                end
                S_ACCEL: begin
                    if (decel_req) begin
                        tick_d = '0;
                    end else begin
                        tick_d = tick_nxt;
                        if (tick_hit) pwm_d = pwm_up;
                    end
                end
                S_CRUISE: tick_d = '0;
                S_DECEL: begin
                    if (dir_mis && pwm_q == PW'(pwm_min)) begin
                        dir_d  = want_q;
                        tick_d = '0;
                    end else if (!dir_mis && !near) begin
                        tick_d = '0;
                    end else begin
                        tick_d = tick_nxt;
                        if (tick_hit) pwm_d = pwm_dn;
                    end
                end
                S_HOLD: begin
                    if (in_band) begin
                        if (settle_q != SET_W'(settle_cycles)) settle_d = settle_q + SET_W'(1);
                    end else begin
                        pwm_d    = PW'(pwm_min);
                        dir_d    = want_q;
                        tick_d   = '0;
                        settle_d = '0;
                    end
                end
                default: begin
                    pwm_d    = '0;
                    dir_d    = DIR_NONE;
                    tick_d   = '0;
                    settle_d = '0;
                end
            endcase
        end
    end

    // Outputs: pass-through switches on enable without waiting for a clock edge.
    always_comb begin
        pwm_duty_out      = enable ? pwm_q : pwm_duty_in;
        dir_out           = enable ? dir_q : dir_in;
        driver_enable_out = enable ? 1'b1  : driver_enable_in;
        busy              = (state_q == S_ACCEL) || (state_q == S_CRUISE) || (state_q == S_DECEL);
        at_target         = (state_q == S_HOLD) && (settle_q == SET_W'(settle_cycles));
    end

endmodule

// File: tb/tb_position_profile_control.sv
// Directed bench for position_profile_control: a vector table of single-move
// scenarios followed by hand-written multi-cycle sequences.
module tb_position_profile_control;
    import position_profile_control_pkg::*;

    logic                sys_clk;
    logic                reset;
    logic                enable;
    logic [31:0]         encoder_position;
    logic [31:0]         target_position;
    logic [31:0]         pwm_duty_in;
    rotation_direction_t dir_in;
    logic                driver_enable_in;
    logic [31:0]         pwm_duty_out;
    rotation_direction_t dir_out;
    logic                driver_enable_out;
    logic                busy;
    logic                at_target;

    int tests;
    int fails;

    position_profile_control dut (
        .sys_clk          (sys_clk),
        .reset            (reset),
        .enable           (enable),
        .encoder_position (encoder_position),
        .target_position  (target_position),
        .pwm_duty_in      (pwm_duty_in),
        .dir_in           (dir_in),
        .driver_enable_in (driver_enable_in),
        .pwm_duty_out     (pwm_duty_out),
        .dir_out          (dir_out),
        .driver_enable_out(driver_enable_out),
        .busy             (busy),
        .at_target        (at_target)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0]         enc;
        logic [31:0]         tgt;
        logic                en;
        logic [31:0]         pin;
        rotation_direction_t din;
        logic                drv;
        int                  wait_n;
        logic [31:0]         e_pwm;
        rotation_direction_t e_dir;
        logic                e_drv;
        logic                e_busy;
        logic                e_at;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic check_out(input string tag, input logic [31:0] pwm, input rotation_direction_t dir,
                             input logic drv, input logic bsy, input logic at);
        check({tag, "_pwm"}, 64'(pwm_duty_out), 64'(pwm));
        check({tag, "_dir"}, 64'(dir_out), 64'(dir));
        check({tag, "_drv"}, 64'(driver_enable_out), 64'(drv));
        check({tag, "_busy"}, 64'(busy), 64'(bsy));
        check({tag, "_at"}, 64'(at_target), 64'(at));
    endtask

    // Reset, load positions, then release reset with enable low for one edge
    // so the distance register holds the real distance before enable rises.
    task automatic restart(input logic [31:0] e, input logic [31:0] t);
        @(negedge sys_clk);
        reset            = 1'b1;
        enable           = 1'b0;
        encoder_position = e;
        target_position  = t;
        pwm_duty_in      = '0;
        dir_in           = DIR_NONE;
        driver_enable_in = 1'b0;
        @(negedge sys_clk);
        reset = 1'b0;
        @(negedge sys_clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        enable = 1'b0;
        encoder_position = '0;
        target_position = '0;
        pwm_duty_in = 32'd55;
        dir_in = CW;
        driver_enable_in = 1'b0;

        vecs[0]  = '{32'd0,         32'd1000,        1'b1, 32'd7,  DIR_NONE, 1'b0, 1,  32'd100, CW,        1'b1, 1'b1, 1'b0};
        vecs[1]  = '{32'd1000,      32'd0,           1'b1, 32'd7,  DIR_NONE, 1'b0, 1,  32'd100, CCW,       1'b1, 1'b1, 1'b0};
        vecs[2]  = '{32'hFFFF_FFF0, 32'h10,          1'b1, 32'd7,  DIR_NONE, 1'b0, 1,  32'd100, CW,        1'b1, 1'b1, 1'b0};
        vecs[3]  = '{32'd0,         32'h8000_0000,   1'b1, 32'd7,  DIR_NONE, 1'b0, 1,  32'd100, CCW,       1'b1, 1'b1, 1'b0};
        vecs[4]  = '{32'hFFFF_FFFE, 32'd2,           1'b1, 32'd7,  DIR_NONE, 1'b0, 1,  32'd100, CW,        1'b1, 1'b1, 1'b0};
        vecs[5]  = '{32'd5,         32'd5,           1'b1, 32'd7,  DIR_NONE, 1'b0, 1,  32'd0,   DIR_BRAKE, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{32'd5,         32'd5,           1'b1, 32'd7,  DIR_NONE, 1'b0, 8,  32'd0,   DIR_BRAKE, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{32'd5,         32'd5,           1'b1, 32'd7,  DIR_NONE, 1'b0, 9,  32'd0,   DIR_BRAKE, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{32'd5,         32'd6,           1'b1, 32'd7,  DIR_NONE, 1'b0, 1,  32'd0,   DIR_BRAKE, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{32'd6,         32'd4,           1'b1, 32'd7,  DIR_NONE, 1'b0, 1,  32'd100, CCW,       1'b1, 1'b1, 1'b0};
        vecs[10] = '{32'd0,         32'd1000,        1'b1, 32'd7,  DIR_NONE, 1'b0, 5,  32'd150, CW,        1'b1, 1'b1, 1'b0};
        vecs[11] = '{32'd0,         32'd1000,        1'b1, 32'd7,  DIR_NONE, 1'b0, 17, 32'd300, CW,        1'b1, 1'b1, 1'b0};
        vecs[12] = '{32'd0,         32'd1000,        1'b0, 32'd77, CCW,      1'b0, 1,  32'd77,  CCW,       1'b0, 1'b0, 1'b0};
        vecs[13] = '{32'd0,         32'd21,          1'b1, 32'd7,  DIR_NONE, 1'b0, 5,  32'd150, CW,        1'b1, 1'b1, 1'b0};
        vecs[14] = '{32'd0,         32'd20,          1'b1, 32'd7,  DIR_NONE, 1'b0, 5,  32'd100, CW,        1'b1, 1'b1, 1'b0};

        // Reset wins over enable.
        step(2);
        enable = 1'b1;
        step(1);
        check_out("reset_en", 32'd0, DIR_NONE, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            restart(vecs[i].enc, vecs[i].tgt);
            pwm_duty_in      = vecs[i].pin;
            dir_in           = vecs[i].din;
            driver_enable_in = vecs[i].drv;
            enable           = vecs[i].en;
            step(vecs[i].wait_n);
            check_out($sformatf("vec%0d", i), vecs[i].e_pwm, vecs[i].e_dir,
                      vecs[i].e_drv, vecs[i].e_busy, vecs[i].e_at);
        end

        // Full move: ramp up, cruise, decelerate, hold, settle, then retarget.
        restart(32'd0, 32'd1000);
        enable = 1'b1;
        step(1);
        check_out("mv_start", 32'd100, CW, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step(4);
            check($sformatf("mv_up%0d", k), 64'(pwm_duty_out), 64'(100 + 50 * k));
        end
        step(3);
        check_out("mv_cruise", 32'd300, CW, 1'b1, 1'b1, 1'b0);
        encoder_position = 32'd980;
        step(2);
        check("mv_decel0", 64'(pwm_duty_out), 64'd300);
        for (int k = 1; k <= 4; k++) begin
            step(4);
            check($sformatf("mv_dn%0d", k), 64'(pwm_duty_out), 64'(300 - 50 * k));
        end
        step(4);
        check_out("mv_floor", 32'd100, CW, 1'b1, 1'b1, 1'b0);
        encoder_position = 32'd1000;
        step(2);
        check_out("mv_hold", 32'd0, DIR_BRAKE, 1'b1, 1'b0, 1'b0);
        step(7);
        check("mv_settle7", 64'(at_target), 64'd0);
        step(1);
        check("mv_settle8", 64'(at_target), 64'd1);
        target_position = 32'd1100;
        step(2);
        check_out("mv_retgt", 32'd100, CW, 1'b1, 1'b1, 1'b0);

        // Target reversal during cruise: ramp down, flip to CCW at the floor, ramp up.
        restart(32'd0, 32'd1000);
        enable = 1'b1;
        step(17);
        check("rev_cruise", 64'(pwm_duty_out), 64'd300);
        encoder_position = 32'd500;
        target_position  = 32'd0;
        step(2);
        check_out("rev_d0", 32'd300, CW, 1'b1, 1'b1, 1'b0);
        step(16);
        check_out("rev_floor", 32'd100, CW, 1'b1, 1'b1, 1'b0);
        step(1);
        check_out("rev_flip", 32'd100, CCW, 1'b1, 1'b1, 1'b0);
        step(4);
        check_out("rev_up", 32'd150, CCW, 1'b1, 1'b1, 1'b0);

        // Enable drop mid-ramp: pass-through in the same cycle, IDLE on the next edge.
        restart(32'd0, 32'd1000);
        enable = 1'b1;
        step(5);
        pwm_duty_in      = 32'd42;
        dir_in           = CCW;
        driver_enable_in = 1'b0;
        enable           = 1'b0;
        #1;
        check_out("dis_same", 32'd42, CCW, 1'b0, 1'b1, 1'b0);
        step(1);
        check_out("dis_next", 32'd42, CCW, 1'b0, 1'b0, 1'b0);
        enable = 1'b1;
        #1;
        check_out("idle_en", 32'd0, DIR_NONE, 1'b1, 1'b0, 1'b0);

        // Reset during cruise clears everything, including the distance register.
        step(17);
        check("rst_cruise", 64'(pwm_duty_out), 64'd300);
        reset = 1'b1;
        step(1);
        check_out("rst_mid", 32'd0, DIR_NONE, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        step(1);
        check_out("rst_dist0", 32'd0, DIR_BRAKE, 1'b1, 1'b0, 1'b0);
        step(1);
        check_out("rst_resume", 32'd100, CW, 1'b1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/position_profile_control.md
POSITION_PROFILE_CONTROL -- requirements
Module: position_profile_control

Interface
REQ-001 SHALL provide these parameters (name, default, meaning):
- counter_width, 32, encoder/target position width
- pwm_counter_width, 32, duty width
- pwm_min, 100, lowest running duty
- pwm_max, 300, cruise duty; pwm_min <= pwm_max
- ramp_step, 50, duty change per ramp tick
- update_divider, 4, sys_clk cycles per ramp tick (>= 1)
- decel_distance, 20, distance at or below which the block decelerates
- deadband, 1, distance at or below which the target counts as reached
- settle_cycles, 8, consecutive in-deadband cycles before at_target asserts
REQ-002 SHALL provide these ports (name, direction, width, meaning):
- sys_clk  in  1  the only clock
- reset  in  1  synchronous, active-high
- enable  in  1  profile control active; low = pass-through
- encoder_position  in  counter_width  current position, modular
- target_position  in  counter_width  commanded position, modular
- pwm_duty_in  in  pwm_counter_width  pass-through duty
- dir_in  in  rotation_direction_t  pass-through direction
- driver_enable_in  in  1  pass-through driver enable
- pwm_duty_out  out  pwm_counter_width  duty to driver
- dir_out  out  rotation_direction_t  direction to driver
- driver_enable_out  out  1  driver enable
- busy  out  1  state is ACCEL, CRUISE or DECEL
- at_target  out  1  settled inside deadband
REQ-003 SHALL use one clock, sys_clk; reset SHALL be synchronous and active-high.

Function
REQ-004 SHALL register error = target_position - encoder_position (mod 2^counter_width) every cycle. If error < 2^(counter_width-1): want_dir = CW, distance = error. Otherwise, including error exactly 2^(counter_width-1): want_dir = CCW, distance = encoder_position - target_position. Latency is one cycle.
REQ-005 SHALL use states IDLE, ACCEL, CRUISE, DECEL, HOLD, with registered duty `pwm_`, registered direction `dir_`, ramp-tick counter `tick_` (0..update_divider-1) and settle counter `settle_`.
REQ-006 In IDLE with enable=1, the block SHALL go next cycle to:
- HOLD if distance <= deadband;
- otherwise ACCEL, with pwm_ = pwm_min, dir_ = want_dir, tick_ = 0.
REQ-007 A ramp tick SHALL occur on the cycle tick_ = update_divider-1, after which tick_ wraps to 0. tick_ SHALL count only in ACCEL and DECEL.
REQ-008 ACCEL: on each tick, pwm_ = min(pwm_ + ramp_step, pwm_max). On reaching pwm_max the state SHALL go to CRUISE. Sums SHALL be computed one bit wider to avoid overflow.
REQ-009 From ACCEL or CRUISE, the state SHALL go to DECEL when distance <= decel_distance or want_dir != dir_. This condition has priority over REQ-008.
REQ-010 DECEL: on each tick, pwm_ = max(pwm_ - ramp_step, pwm_min), computed without underflow.
REQ-011 DECEL exits (one cycle):
- if want_dir != dir_ and pwm_ = pwm_min, SHALL set dir_ = want_dir and go to ACCEL (reversal);
- if want_dir = dir_ and distance > decel_distance, SHALL go to ACCEL from the current pwm_ (retarget further away).
REQ-012 From any running state, distance <= deadband SHALL go to HOLD next cycle, with pwm_ = 0, dir_ = DIR_BRAKE, settle_ = 0. This has priority over REQ-008..REQ-011.
REQ-013 HOLD:
- settle_ increments, saturating at settle_cycles, while distance <= deadband;
- at_target = 1 only when settle_ = settle_cycles;
- distance > deadband SHALL clear at_target and settle_ and go to ACCEL, with pwm_ = pwm_min and dir_ = want_dir.
REQ-014 enable=0 in any state SHALL go to IDLE next cycle, clearing pwm_, at_target and settle_, with dir_ = DIR_NONE. Outputs SHALL switch to pass-through combinationally in the same cycle.
REQ-015 Output muxing:
- pwm_duty_out = enable ? pwm_ : pwm_duty_in;
- dir_out = enable ? dir_ : dir_in;
- driver_enable_out = enable ? 1 : driver_enable_in.
In IDLE with enable=1, outputs SHALL be pwm 0 and DIR_NONE.
REQ-016 Modular wrap SHALL be handled per REQ-004. Example for counter_width=32: encoder 0xFFFF_FFFE, target 0x0000_0002 gives CW, distance 4.

Reset
REQ-017 reset=1 SHALL set on the next sys_clk edge: state IDLE, pwm_ = 0, dir_ = DIR_NONE, tick_ = 0, settle_ = 0, at_target = 0, distance register = 0.
REQ-018 Reset SHALL take priority over enable. Reset mid-move SHALL take effect on that edge, with no decel ramp.

Verification
REQ-019 encoder=0, target=1000, enable rises -> ACCEL at duty 100 CW; 150, 200, 250, 300 at 4-cycle spacing; then CRUISE; busy=1.
REQ-020 Encoder advances to 980 -> DECEL; duty steps down by 50 every 4 cycles to a floor of 100; encoder=1000 -> HOLD, duty 0, DIR_BRAKE, at_target=1 after 8 cycles.
REQ-021 Target changes from 1000 to 0 during CRUISE at encoder 500 -> DECEL to 100, then CCW at 100, then ACCEL.
REQ-022 Wrap case: encoder 0xFFFF_FFF0, target 0x10 -> CW, distance 32; error exactly 0x8000_0000 -> CCW.
REQ-023 enable drops during ACCEL -> outputs equal pass-through inputs the same cycle; state IDLE next cycle. Reset asserted during CRUISE -> all REQ-017 values on the next edge.
